// File: rtl/conv_img_stripe_bram_if.sv
// Pixel-load, engine-start and image read-port signals of the
// striped image BRAM responder.
interface conv_img_stripe_bram_if #(
  parameter int DATA_WIDTH = 8,
  parameter int IMG_D      = 4,
  parameter int FILTER_W   = 3,
  parameter int ADDR_W     = 5
);
  logic [DATA_WIDTH*IMG_D-1:0]          pix_in;
  logic                                 pix_val;
  logic                                 pix_rdy;
  logic                                 conv_val;
  logic                                 conv_rdy;
  logic                                 conv_done;
  logic [ADDR_W*IMG_D*FILTER_W-1:0]     img_rdaddress;
  logic [DATA_WIDTH*IMG_D*FILTER_W-1:0] img_data_out;
  logic                                 busy;

  modport master (
    output pix_in, pix_val, conv_rdy, conv_done, img_rdaddress,
    input  pix_rdy, conv_val, img_data_out, busy
  );

  modport slave (
    input  pix_in, pix_val, conv_rdy, conv_done, img_rdaddress,
    output pix_rdy, conv_val, img_data_out, busy
  );
endinterface

// File: rtl/conv_img_stripe_bram.sv
// Image-side responder: loads a raster image into per-channel column-stripe
// banks, starts the conv engine and serves its packed read-address bus.
module conv_img_stripe_bram #(
  parameter int DATA_WIDTH = 8,
  parameter int IMG_W      = 8,
  parameter int IMG_H      = 8,
  parameter int IMG_D      = 4,
  parameter int FILTER_W   = 3,
  parameter int STRIPE_W   = (IMG_W + FILTER_W - 1) / FILTER_W,
  parameter int STRIPE_DEPTH = STRIPE_W * IMG_H,
  parameter int ADDR_W     = $clog2(STRIPE_DEPTH)
) (
  input logic clk,
  input logic reset,
  conv_img_stripe_bram_if.slave bus
);
  localparam int NB = IMG_D * FILTER_W;
  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int BW = (FILTER_W > 1) ? $clog2(FILTER_W) : 1;

  typedef enum logic [1:0] {LOAD, START, RUN} state_t;

  state_t state_q;
  logic   pix_rdy_q, conv_val_q, busy_q;

  logic [CW-1:0]     col_w_q, col_w_d;
  logic [RW-1:0]     row_h_q, row_h_d;
  logic [BW-1:0]     bank_sel_q, bank_sel_d;
  logic [ADDR_W-1:0] stripe_col_q, stripe_col_d;
  logic [ADDR_W-1:0] row_base_q, row_base_d;
  logic [ADDR_W-1:0] wr_addr;
  logic              wr_en, last_col, last_beat;

  assign wr_en     = pix_rdy_q && bus.pix_val && !reset;
  assign last_col  = (col_w_q == CW'(IMG_W - 1));
  assign last_beat = last_col && (row_h_q == RW'(IMG_H - 1));
  assign wr_addr   = row_base_q + stripe_col_q;

  assign bus.pix_rdy  = pix_rdy_q;
  assign bus.conv_val = conv_val_q;
  assign bus.busy     = busy_q;

  // Outputs are registered alongside the state so they depend on state only
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= LOAD;
      pix_rdy_q  <= 1'b1;
      conv_val_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      unique case (state_q)
        LOAD: if (wr_en && last_beat) begin
          state_q    <= START;
          pix_rdy_q  <= 1'b0;
          conv_val_q <= 1'b1;
          busy_q     <= 1'b1;
        end
        START: if (conv_val_q && bus.conv_rdy) begin
          state_q    <= RUN;
          conv_val_q <= 1'b0;
        end
        RUN: if (bus.conv_done) begin
          state_q   <= LOAD;
          pix_rdy_q <= 1'b1;
          busy_q    <= 1'b0;
        end
        default: begin
          state_q    <= LOAD;
          pix_rdy_q  <= 1'b1;
          conv_val_q <= 1'b0;
          busy_q     <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    col_w_d      = col_w_q;
    row_h_d      = row_h_q;
    bank_sel_d   = bank_sel_q;
    stripe_col_d = stripe_col_q;
    row_base_d   = row_base_q;
    if (wr_en) begin
      if (last_col) begin
        col_w_d      = '0;
        bank_sel_d   = '0;
        stripe_col_d = '0;
        if (last_beat) begin
          row_h_d    = '0;
          row_base_d = '0;
        end else begin
          row_h_d    = row_h_q + 1'b1;
          row_base_d = row_base_q + ADDR_W'(STRIPE_W);
        end
      end else begin
        col_w_d = col_w_q + 1'b1;
        if (bank_sel_q == BW'(FILTER_W - 1)) begin
          bank_sel_d   = '0;
          stripe_col_d = stripe_col_q + 1'b1;
        end else begin
          bank_sel_d = bank_sel_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      col_w_q      <= '0;
      row_h_q      <= '0;
      bank_sel_q   <= '0;
      stripe_col_q <= '0;
      row_base_q   <= '0;
    end else begin
      col_w_q      <= col_w_d;
      row_h_q      <= row_h_d;
      bank_sel_q   <= bank_sel_d;
      stripe_col_q <= stripe_col_d;
      row_base_q   <= row_base_d;
    end
  end

  for (genvar f = 0; f < NB; f++) begin : g_bank
    localparam int C = f / FILTER_W;
    localparam int B = f % FILTER_W;

    logic [DATA_WIDTH-1:0] mem [STRIPE_DEPTH];
    logic [ADDR_W-1:0]     rd_addr;
    logic [DATA_WIDTH-1:0] rd_d, rd_q;
    logic                  wr_hit, rd_ok;

    assign rd_addr = bus.img_rdaddress[f*ADDR_W +: ADDR_W];
    assign wr_hit  = wr_en && (bank_sel_q == BW'(B));
    assign rd_ok   = {1'b0, rd_addr} < (ADDR_W + 1)'(STRIPE_DEPTH);

    always_ff @(posedge clk) begin
      if (wr_hit) mem[wr_addr] <= bus.pix_in[C*DATA_WIDTH +: DATA_WIDTH];
    end

    // Read sees pre-write contents on a same-cycle collision
    always_comb begin
      rd_d = '0;
      if (rd_ok) rd_d = mem[rd_addr];
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) rd_q <= '0;
      else       rd_q <= rd_d;
    end

    assign bus.img_data_out[f*DATA_WIDTH +: DATA_WIDTH] = rd_q;
  end
endmodule
